// File: rtl/debug_unit.sv
// Host debug controller: UART commands load program words, run or single-step the core, then dump its snapshot.
// Write strobe 1 cycle after 4th byte; dump bytes paced by i_tx_done; rx bytes ignored outside IDLE/LOAD.
module debug_unit #(
    parameter int          DEBUG_W   = 2554,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_program_memory_write,
    output logic [31:0]        o_instruction_write,
    output logic [ADDR_W-1:0]  o_address_write,
    output logic               o_step,
    input  logic [DEBUG_W-1:0] i_to_debug,
    input  logic               i_stop_signal,
    output logic               o_busy
);

    localparam int NB    = (DEBUG_W + 7) / 8;
    localparam int SH_W  = NB * 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_RUN, S_STEP, S_DUMP, S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_word;
    logic [1:0]         r_byte_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic               r_step;
    logic [SH_W-1:0]    r_shadow;
    logic [CNT_W-1:0]   r_dump_cnt;
    logic [7:0]         r_tx_data;
    logic               r_tx_start;
    logic [SH_W-1:0]    w_dbg_pad;
    logic               w_tx_ack;
    logic               w_last;
    logic               w_send;
    logic               w_enter_dump;

    always_comb begin
        w_dbg_pad                = '0;
        w_dbg_pad[DEBUG_W-1:0]   = i_to_debug;
    end

    // A done coinciding with our own start pulse cannot belong to the new byte.
    assign w_tx_ack     = i_tx_done && !r_tx_start;
    assign w_last       = (r_dump_cnt == CNT_W'(NB - 1));
    assign w_send       = (r_state == S_DUMP) || ((r_state == S_WAIT) && w_tx_ack && !w_last);
    assign w_enter_dump = ((r_state == S_RUN) && i_stop_signal) || (r_state == S_STEP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h4C:   w_next = S_LOAD;
                        8'h43:   w_next = S_RUN;
                        8'h53:   w_next = S_STEP;
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_LOAD:  if (i_rx_valid && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
            S_WRITE: w_next = (r_word == HALT_WORD) ? S_IDLE : S_LOAD;
            S_RUN:   if (i_stop_signal) w_next = S_DUMP;
            S_STEP:  w_next = S_DUMP;
            S_DUMP:  w_next = S_WAIT;
            S_WAIT:  if (w_tx_ack && w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_step     <= 1'b0;
            r_shadow   <= '0;
            r_dump_cnt <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            r_we       <= 1'b0;
            r_tx_start <= 1'b0;
            if ((r_state == S_IDLE) && i_rx_valid) begin
                if (i_rx_data == 8'h4C) begin
                    r_addr     <= '0;
                    r_byte_cnt <= '0;
                end
                if ((i_rx_data == 8'h43) || (i_rx_data == 8'h53)) r_step <= 1'b1;
            end
            if ((r_state == S_LOAD) && i_rx_valid) begin
                r_word[{r_byte_cnt, 3'b000} +: 8] <= i_rx_data;
                r_byte_cnt                        <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'd3) r_we <= 1'b1;
            end
            if (r_state == S_WRITE) r_addr <= r_addr + ADDR_W'(1);
            if (w_enter_dump) begin
                r_step     <= 1'b0;
                r_shadow   <= w_dbg_pad;
                r_dump_cnt <= '0;
            end
            // Shadow shifts down so the next byte is always in the low lane.
            if (w_send) begin
                r_tx_data  <= r_shadow[7:0];
                r_shadow   <= r_shadow >> 8;
                r_tx_start <= 1'b1;
                if (r_state == S_WAIT) r_dump_cnt <= r_dump_cnt + CNT_W'(1);
            end
        end
    end

    assign o_tx_data              = r_tx_data;
    assign o_tx_start             = r_tx_start;
    assign o_program_memory_write = r_we;
    assign o_instruction_write    = r_word;
    assign o_address_write        = r_addr;
    assign o_step                 = r_step;
    assign o_busy                 = (r_state != S_IDLE);

endmodule
